// File: rtl/parser_typedefs_pkg.sv
// Shared types for the N3 (GTP-U) parser pipeline: flow-classifier FSM states,
// the packet header signature width, and the flow table entry layout.
package parser_typedefs_pkg;

  localparam int PHS_W      = 120;
  localparam int FLOW_CNT_W = 16;

  typedef enum logic [1:0] {
    FC_IDLE,
    FC_SEARCH,
    FC_INSERT,
    FC_RESP
  } FLOW_STATES;

  // A flow classifier built with a narrower counter uses the low bits of count.
  typedef struct packed {
    logic                  valid;
    logic [PHS_W-1:0]      key;
    logic [FLOW_CNT_W-1:0] count;
  } FlowEntry;

endpackage

// File: rtl/phs_sync_fifo.sv
// Single-clock FIFO with full/empty flags. A push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module phs_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // NOTE: storage is not reset; the pointers and count alone define which slots hold data.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/phs_flow_classifier.sv
// Exact-match flow classifier: looks each PHS up in a small flop-based table,
// inserts misses (round-robin eviction when full) and reports flow id / count.
module phs_flow_classifier
  import parser_typedefs_pkg::*;
#(
  parameter int N_ENTRIES  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = FLOW_CNT_W,
  localparam int IDX_W     = $clog2(N_ENTRIES)
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic [PHS_W-1:0] phs_i,
  input  logic             phs_valid_i,
  input  logic             table_clear_i,
  output logic             flow_valid_o,
  input  logic             flow_ready_i,
  output logic [IDX_W-1:0] flow_id_o,
  output logic             flow_new_o,
  output logic [CNT_W-1:0] pkt_count_o,
  output logic [CNT_W-1:0] drop_cnt_o,
  output logic             busy_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

  FLOW_STATES            state_q;
  FLOW_STATES            next_state;
  FlowEntry              table_q [N_ENTRIES];
  logic [PHS_W-1:0]      key_q;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      rr_q;
  logic                  clear_pend_q;
  logic [IDX_W-1:0]      res_id_q;
  logic                  res_new_q;
  logic [CNT_W-1:0]      res_cnt_q;
  logic [CNT_W-1:0]      drop_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [PHS_W-1:0]      fifo_data;
  logic                  pop;
  logic                  apply_clear;
  logic                  hit;
  logic [FLOW_CNT_W-1:0] hit_cnt;
  logic                  free_found;
  logic [IDX_W-1:0]      free_idx;
  logic [IDX_W-1:0]      ins_idx;

  function automatic logic [FLOW_CNT_W-1:0] sat_inc(input logic [FLOW_CNT_W-1:0] c);
    if (c[CNT_W-1:0] == {CNT_W{1'b1}}) return c;
    return c + FLOW_CNT_W'(1);
  endfunction

  phs_sync_fifo #(
    .WIDTH (PHS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (reset_n),
    .push      (phs_valid_i),
    .push_data (phs_i),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A pending clear always wins over a pop so queued lookups see the cleared table.
  assign pop         = (state_q == FC_IDLE) && !clear_pend_q && !fifo_empty;
  assign apply_clear = (state_q == FC_IDLE) && (clear_pend_q || (table_clear_i && !pop));
  assign hit         = (state_q == FC_SEARCH) && table_q[idx_q].valid && (table_q[idx_q].key == key_q);
  assign hit_cnt     = sat_inc(table_q[idx_q].count);
  assign ins_idx     = free_found ? free_idx : rr_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (!table_q[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    next_state = state_q;
    case (state_q)
      FC_IDLE:   if (pop) next_state = FC_SEARCH;
      FC_SEARCH: begin
        if (hit)                    next_state = FC_RESP;
        else if (idx_q == LAST_IDX) next_state = FC_INSERT;
      end
      FC_INSERT: next_state = FC_RESP;
      FC_RESP:   if (flow_ready_i) next_state = FC_IDLE;
      default:   next_state = FC_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state_q      <= FC_IDLE;
      key_q        <= '0;
      idx_q        <= '0;
      rr_q         <= '0;
      clear_pend_q <= 1'b0;
      res_id_q     <= '0;
      res_new_q    <= 1'b0;
      res_cnt_q    <= '0;
      drop_q       <= '0;
      for (int i = 0; i < N_ENTRIES; i++) table_q[i] <= '0;
    end else begin
      state_q <= next_state;

      if (pop) begin
        key_q <= fifo_data;
        idx_q <= '0;
      end else if (state_q == FC_SEARCH && !hit) begin
        idx_q <= idx_q + IDX_W'(1);
      end

      if (hit) begin
        table_q[idx_q].count <= hit_cnt;
        res_id_q             <= idx_q;
        res_new_q            <= 1'b0;
        res_cnt_q            <= hit_cnt[CNT_W-1:0];
      end

      if (state_q == FC_INSERT) begin
        table_q[ins_idx].valid <= 1'b1;
        table_q[ins_idx].key   <= key_q;
        table_q[ins_idx].count <= FLOW_CNT_W'(1);
        res_id_q               <= ins_idx;
        res_new_q              <= 1'b1;
        res_cnt_q              <= CNT_W'(1);
        if (!free_found) rr_q <= rr_q + IDX_W'(1);
      end

      if (apply_clear) begin
        for (int i = 0; i < N_ENTRIES; i++) table_q[i].valid <= 1'b0;
        rr_q         <= '0;
        clear_pend_q <= 1'b0;
      end else if (table_clear_i) begin
        clear_pend_q <= 1'b1;
      end

      if (phs_valid_i && fifo_full && !pop && drop_q != {CNT_W{1'b1}}) begin
        drop_q <= drop_q + CNT_W'(1);
      end
    end
  end

  assign flow_valid_o = (state_q == FC_RESP);
  assign flow_id_o    = res_id_q;
  assign flow_new_o   = res_new_q;
  assign pkt_count_o  = res_cnt_q;
  assign drop_cnt_o   = drop_q;
  assign busy_o       = (state_q != FC_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_phs_flow_classifier.sv
// Bench for phs_flow_classifier (CNT_W=2 build so saturation is reachable):
// directed scenarios with literal expectations plus random traffic against a transaction model.
module tb_phs_flow_classifier;
  import parser_typedefs_pkg::*;

  localparam int N    = 8;
  localparam int D    = 4;
  localparam int CW   = 2;
  localparam int CMAX = 3;

  logic             CLK = 1'b0;
  logic             reset_n;
  logic [PHS_W-1:0] phs_i;
  logic             phs_valid_i;
  logic             table_clear_i;
  logic             flow_valid_o;
  logic             flow_ready_i;
  logic [2:0]       flow_id_o;
  logic             flow_new_o;
  logic [CW-1:0]    pkt_count_o;
  logic [CW-1:0]    drop_cnt_o;
  logic             busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  phs_flow_classifier #(
    .N_ENTRIES  (N),
    .FIFO_DEPTH (D),
    .CNT_W      (CW)
  ) dut (
    .CLK           (CLK),
    .reset_n       (reset_n),
    .phs_i         (phs_i),
    .phs_valid_i   (phs_valid_i),
    .table_clear_i (table_clear_i),
    .flow_valid_o  (flow_valid_o),
    .flow_ready_i  (flow_ready_i),
    .flow_id_o     (flow_id_o),
    .flow_new_o    (flow_new_o),
    .pkt_count_o   (pkt_count_o),
    .drop_cnt_o    (drop_cnt_o),
    .busy_o        (busy_o)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // Transaction-level reference: FIFO contents, one lookup in flight, table as plain arrays.
  logic [PHS_W-1:0] mq [$];
  logic [PHS_W-1:0] mkey [N];
  bit               mval [N];
  int               mcnt [N];
  int               mrr, m_drop, m_due, edges;
  int               m_exp_id, m_exp_new, m_exp_cnt;
  bit               m_busy, m_pend, mon_en = 1'b0;

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < N; i++) begin mval[i] = 1'b0; mcnt[i] = 0; mkey[i] = '0; end
    mrr = 0; m_drop = 0; m_busy = 1'b0; m_pend = 1'b0; m_due = 0;
  endtask

  task automatic model_lookup(input logic [PHS_W-1:0] key, input int u);
    int k, t;
    k = -1;
    for (int i = 0; i < N; i++) if (mval[i] && mkey[i] == key) k = i;
    if (k >= 0) begin
      mcnt[k]   = (mcnt[k] + 1 > CMAX) ? CMAX : mcnt[k] + 1;
      m_exp_id  = k; m_exp_new = 0; m_exp_cnt = mcnt[k];
      m_due     = u + 1 + k;
    end else begin
      t = -1;
      for (int i = N - 1; i >= 0; i--) if (!mval[i]) t = i;
      if (t < 0) begin t = mrr; mrr = (mrr + 1) % N; end
      mkey[t] = key; mval[t] = 1'b1; mcnt[t] = 1;
      m_exp_id = t; m_exp_new = 1; m_exp_cnt = 1;
      m_due    = u + 1 + N;
    end
  endtask

  // Advance the model across the coming posedge using the inputs presented for it.
  task automatic model_step();
    int u;
    bit idle, do_pop, do_clr;
    u = edges + 1;
    if (!reset_n) begin
      model_reset();
    end else begin
      idle   = !m_busy;
      do_pop = idle && !m_pend && (mq.size() > 0);
      do_clr = idle && (m_pend || (table_clear_i && !do_pop));
      if (m_busy && edges >= m_due && flow_ready_i) m_busy = 1'b0;
      if (do_clr) begin
        for (int i = 0; i < N; i++) mval[i] = 1'b0;
        mrr = 0; m_pend = 1'b0;
      end else if (table_clear_i) begin
        m_pend = 1'b1;
      end
      if (phs_valid_i) begin
        if (mq.size() < D || do_pop) mq.push_back(phs_i);
        else if (m_drop < CMAX) m_drop++;
      end
      if (do_pop) begin
        model_lookup(mq.pop_front(), u);
        m_busy = 1'b1;
      end
    end
    edges = u;
  endtask

  always @(negedge CLK) begin
    bit exp_v;
    if (mon_en) begin
      exp_v = m_busy && (edges >= m_due);
      check("mon_valid", int'(flow_valid_o), int'(exp_v));
      if (exp_v) begin
        check("mon_id", int'(flow_id_o), m_exp_id);
        check("mon_new", int'(flow_new_o), m_exp_new);
        check("mon_count", int'(pkt_count_o), m_exp_cnt);
      end
      check("mon_drop", int'(drop_cnt_o), m_drop);
      check("mon_busy", int'(busy_o), int'(m_busy || mq.size() > 0));
    end
    if (!reset_n) mon_en = 1'b1;
    model_step();
  end

  task automatic await_valid(output int waited);
    waited = 0;
    while (!flow_valid_o && waited < 64) begin
      @(posedge CLK); #1;
      waited++;
    end
    check("await_valid", int'(flow_valid_o), 1);
  endtask

  // Strobe one PHS into an idle DUT (ready=1) and return its result and strobe-to-valid edges.
  task automatic lookup(input logic [PHS_W-1:0] p, output int id, output int nw,
                        output int cnt, output int lat);
    int waited;
    phs_i = p; phs_valid_i = 1'b1;
    @(posedge CLK); #1;
    phs_valid_i = 1'b0;
    await_valid(waited);
    lat = 1 + waited;
    id = int'(flow_id_o); nw = int'(flow_new_o); cnt = int'(pkt_count_o);
    @(posedge CLK); #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge CLK);
    #1 reset_n = 1'b1;
  endtask

  function automatic logic [PHS_W-1:0] mk_phs(input logic [7:0] proto, input logic [15:0] sport,
                                               input logic [31:0] dst);
    return {8'd1, 8'd0, sport, 16'd2152, proto, 32'h0a00_0001, dst};
  endfunction

  logic [PHS_W-1:0] pool [16];
  logic [PHS_W-1:0] a_phs;
  logic [127:0]     rnd;

  initial begin
    int id, nw, cnt, lat, waited, got_n;
    int got_ids [5];
    reset_n = 1'b0; phs_i = '0; phs_valid_i = 1'b0; table_clear_i = 1'b0; flow_ready_i = 1'b1;
    edges = 0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1 reset_n = 1'b1;

    // 1: reset held 4 cycles in the middle of traffic
    for (int c = 0; c < 12; c++) begin
      phs_i = mk_phs(8'd6, 16'(c), 32'(c)); phs_valid_i = 1'b1; flow_ready_i = 1'b0;
      @(posedge CLK); #1;
    end
    reset_n = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check("t1_valid", int'(flow_valid_o), 0);
    check("t1_id", int'(flow_id_o), 0);
    check("t1_new", int'(flow_new_o), 0);
    check("t1_count", int'(pkt_count_o), 0);
    check("t1_drop", int'(drop_cnt_o), 0);
    check("t1_busy", int'(busy_o), 0);
    phs_valid_i = 1'b0; flow_ready_i = 1'b1; reset_n = 1'b1;
    lookup(mk_phs(8'd6, 16'd5, 32'd99), id, nw, cnt, lat);
    check("t1_after_new", nw, 1);
    check("t1_after_id", id, 0);

    // 2: same PHS twice; strobe-to-valid = 1 (push) + 2 + k, miss k = N
    apply_reset();
    a_phs = mk_phs(8'd17, 16'd2152, 32'h0a00_0002);
    lookup(a_phs, id, nw, cnt, lat);
    check("t2_first_new", nw, 1); check("t2_first_id", id, 0);
    check("t2_first_cnt", cnt, 1); check("t2_first_lat", lat, 11);
    lookup(a_phs, id, nw, cnt, lat);
    check("t2_second_new", nw, 0); check("t2_second_id", id, 0);
    check("t2_second_cnt", cnt, 2); check("t2_second_lat", lat, 3);

    // 3: fill, then round-robin eviction
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      lookup(mk_phs(8'd17, 16'd100, 32'(i)), id, nw, cnt, lat);
      check("t3_fill_id", id, i);
      check("t3_fill_new", nw, 1);
    end
    lookup(mk_phs(8'd17, 16'd100, 32'd8), id, nw, cnt, lat);
    check("t3_ninth_id", id, 0); check("t3_ninth_new", nw, 1);
    lookup(mk_phs(8'd17, 16'd100, 32'd9), id, nw, cnt, lat);
    check("t3_tenth_id", id, 1);
    lookup(mk_phs(8'd17, 16'd100, 32'd0), id, nw, cnt, lat);
    check("t3_resend_new", nw, 1); check("t3_resend_id", id, 2);

    // 4: backpressure and overflow
    apply_reset();
    flow_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      phs_i = mk_phs(8'd17, 16'd200, 32'(i)); phs_valid_i = 1'b1;
      @(posedge CLK); #1;
    end
    phs_valid_i = 1'b0;
    check("t4_drop", int'(drop_cnt_o), 1);
    check("t4_busy", int'(busy_o), 1);
    repeat (15) @(posedge CLK);
    #1;
    check("t4_held_valid", int'(flow_valid_o), 1);
    check("t4_held_id", int'(flow_id_o), 0);
    repeat (5) @(posedge CLK);
    #1;
    check("t4_frozen_id", int'(flow_id_o), 0);
    check("t4_frozen_cnt", int'(pkt_count_o), 1);
    flow_ready_i = 1'b1;
    got_n = 0;
    for (int c = 0; c < 200 && got_n < 5; c++) begin
      if (flow_valid_o) begin got_ids[got_n] = int'(flow_id_o); got_n++; end
      @(posedge CLK); #1;
    end
    check("t4_results", got_n, 5);
    for (int i = 0; i < 5; i++) check("t4_order", (i < got_n) ? got_ids[i] : -1, i);

    // 5: clear during the search of a known PHS
    apply_reset();
    lookup(a_phs, id, nw, cnt, lat);
    phs_i = a_phs; phs_valid_i = 1'b1;
    @(posedge CLK); #1;
    phs_valid_i = 1'b0;
    @(posedge CLK); #1;
    table_clear_i = 1'b1;
    @(posedge CLK); #1;
    table_clear_i = 1'b0;
    await_valid(waited);
    check("t5_inflight_new", int'(flow_new_o), 0);
    check("t5_inflight_cnt", int'(pkt_count_o), 2);
    @(posedge CLK); #1;
    lookup(a_phs, id, nw, cnt, lat);
    check("t5_after_new", nw, 1); check("t5_after_id", id, 0); check("t5_after_cnt", cnt, 1);

    // 6: counter saturation (CW=2)
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      lookup(a_phs, id, nw, cnt, lat);
      check("t6_count", cnt, (i > CMAX) ? CMAX : i);
    end

    // Random traffic against the model, including near-identical keys
    for (int i = 0; i < 8; i++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      pool[i] = rnd[PHS_W-1:0];
      pool[i+8] = pool[i] ^ (PHS_W'(1) << $urandom_range(PHS_W - 1));
    end
    for (int c = 0; c < 1500; c++) begin
      phs_valid_i   = ($urandom_range(3) == 0);
      phs_i         = pool[$urandom_range(15)];
      flow_ready_i  = ($urandom_range(3) != 0);
      table_clear_i = ($urandom_range(63) == 0);
      @(posedge CLK); #1;
    end
    phs_valid_i = 1'b0; table_clear_i = 1'b0; flow_ready_i = 1'b1;
    repeat (60) @(posedge CLK);
    #1;
    check("drain_busy", int'(busy_o), 0);
    @(negedge CLK);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
